n64_vdemux_info: RTL
====================

// Module: n64_vdemux_info
//
// PURPOSE
// First stage after the N64 digital video input pins. Demultiplexes the
// 4-phase D_i bus (sync nibble, R, G, B) into a registered previous-pixel
// vector and a two-pixel-old sync nibble. Derives the per-pixel phase
// counter, the blurry-pixel position, PAL/NTSC (line count) and 480i.
// Its outputs feed n64_deblur directly, plus downstream scaler/DAC stages.
//
// PARAMETERS
// color_width_i  7     width of one colour component on D_i
// LINECNT_W      10    width of the per-frame line counter (saturating)
// PAL_LINE_TH    287   vmode=1 (PAL) when lines per frame > this value
//
// PORTS
// nCLK              in   1   N64 video clock; all logic on negedge nCLK
// nRST              in   1   reset: synchronous, active-low
// nDSYNC            in   1   low on the sync-nibble phase of each pixel
// D_i               in   7   multiplexed video data bus
// vdata_sync_2pre   out  4   sync nibble of pixel n-2 {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
// vdata_pre         out  25  pixel n-1 {sync[3:0],R[6:0],G[6:0],B[6:0]}, MSB..LSB
// data_cnt          out  2   phase of D_i at the current edge: 0 sync,1 R,2 G,3 B
// n64_480i          out  1   1 = interlaced mode detected
// vmode             out  1   1 = PAL (>PAL_LINE_TH lines), 0 = NTSC
// blurry_pixel_pos  out  1   pixel-parity flag; toggles once per pixel
//
// BEHAVIOUR
// - Reset (nRST=0 at negedge nCLK): vdata_sync_2pre=4'hF, vdata_pre sync=4'hF,
//   colours=0, data_cnt=0, n64_480i=0, vmode=0, blurry_pixel_pos=1,
//   line_cnt=0, field state cleared. Reset wins over every other update.
// - data_cnt: nDSYNC=0 -> 2'b01; else data_cnt+1 (3 wraps to 0). It thus
//   names the phase of D_i sampled on the same edge one cycle later;
//   consumers pair data_cnt with D_i combinationally.
// - Sync edge (nDSYNC=0): vdata_sync_2pre <= vdata_pre[24:21];
//   vdata_pre[24:21] <= D_i[3:0].
// - Colour capture (nDSYNC=1): data_cnt=1 -> R slice <= D_i; 2 -> G; 3 -> B.
//   Slices update on the edge after consumers compare against them (1 clk latency).
// - Missing nDSYNC: counter free-runs/wraps; data captured per data_cnt; no error flag.
// - blurry_pixel_pos, at sync edge only: rising nHSYNC (vdata_pre[22]=0 &
//   D_i[1]=1) -> 1; else toggle. Constant between sync edges.
// - line_cnt: +1 at sync edge with rising nHSYNC, saturates at all-ones.
// - Frame event = sync edge with vdata_pre[24]=1 & D_i[3]=0 (nVSYNC fall):
//   vmode <= (line_cnt > PAL_LINE_TH); line_cnt <= 0 (same edge as an
//   HSYNC rise: clear wins, rise not counted).
//   field <= vdata_pre[22] (nHSYNC level at VSYNC fall); tgl = field^prev_field;
//   2-bit history of tgl: two consecutive toggles -> n64_480i=1,
//   two consecutive non-toggles -> n64_480i=0, mixed -> hold.
// - No outputs change between resets except as described; all outputs registered.
//
// TESTING
// 1 Reset: hold nRST=0 3 clks with random D_i -> outputs equal reset values listed.
// 2 Demux: nDSYNC 0,1,1,1 with D_i=4'hB,7'h55,7'h2A,7'h7F -> data_cnt 1,2,3,0;
//   after next sync vdata_pre={4'hB,55,2A,7F}, vdata_sync_2pre=prior sync.
// 3 Parity: 5 pixels after an nHSYNC rise -> blurry_pixel_pos 1,0,1,0,1.
// 4 Mode: 263 lines/frame -> vmode=0; 313 lines/frame -> vmode=1 at VSYNC fall.
// 5 480i: VSYNC fall at nHSYNC level 0,1,0,1 -> n64_480i=1 after 3rd frame;
//   then 1,1,1 -> n64_480i=0 after 2nd equal frame.
// 6 Reset mid-frame with line_cnt=150, n64_480i=1 -> all cleared next edge;
//   next frame counts from 0.

Source files
------------

// File: rtl/n64_vdemux_info.sv
// Input demultiplexer for the N64 digital video bus: splits the 4-phase D_i stream
// into sync/R/G/B, and derives pixel phase, blur parity, line count, PAL/NTSC and 480i.
module n64_vdemux_info #(
  parameter int color_width_i = 7,
  parameter int LINECNT_W     = 10,
  parameter int PAL_LINE_TH   = 287
) (
  input  logic                         nCLK,
  input  logic                         nRST,
  input  logic                         nDSYNC,
  input  logic [color_width_i-1:0]     D_i,
  output logic [3:0]                   vdata_sync_2pre,
  output logic [3*color_width_i+3:0]   vdata_pre,
  output logic [1:0]                   data_cnt,
  output logic                         n64_480i,
  output logic                         vmode,
  output logic                         blurry_pixel_pos
);

  localparam int CW = color_width_i;
  localparam int VW = 3*CW + 4;
  localparam logic [LINECNT_W-1:0] PAL_TH_L = PAL_LINE_TH[LINECNT_W-1:0];

  logic [LINECNT_W-1:0] line_cnt;
  logic                 field;
  logic [1:0]           tgl_hist;
  logic                 hsync_rise;
  logic                 vsync_fall;
  logic                 tgl;
  logic [1:0]           tgl_next;

  function automatic logic [LINECNT_W-1:0] sat_inc(input logic [LINECNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Sync nibble layout {nVSYNC, nCLAMP, nHSYNC, nCSYNC}; edges are judged
  // between the stored previous nibble and the one on D_i right now.
  assign hsync_rise = ~nDSYNC & ~vdata_pre[VW-3] &  D_i[1];
  assign vsync_fall = ~nDSYNC &  vdata_pre[VW-1] & ~D_i[3];
  assign tgl        = vdata_pre[VW-3] ^ field;
  assign tgl_next   = {tgl_hist[0], tgl};

  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      data_cnt         <= 2'd0;
      vdata_sync_2pre  <= 4'hF;
      vdata_pre        <= {4'hF, {(3*CW){1'b0}}};
      blurry_pixel_pos <= 1'b1;
      line_cnt         <= '0;
      vmode            <= 1'b0;
      n64_480i         <= 1'b0;
      field            <= 1'b0;
      tgl_hist         <= 2'b00;
    end else begin
      if (!nDSYNC) begin
        data_cnt          <= 2'd1;
        vdata_sync_2pre   <= vdata_pre[VW-1 -: 4];
        vdata_pre[VW-1 -: 4] <= D_i[3:0];
        blurry_pixel_pos  <= hsync_rise ? 1'b1 : ~blurry_pixel_pos;
      end else begin
        data_cnt <= data_cnt + 2'd1;
        // A phase-0 slot without nDSYNC carries no sync nibble worth keeping.
        case (data_cnt)
          2'd1:    vdata_pre[3*CW-1 -: CW] <= D_i;
          2'd2:    vdata_pre[2*CW-1 -: CW] <= D_i;
          2'd3:    vdata_pre[CW-1:0]       <= D_i;
          default: ;
        endcase
      end

      // Frame boundary: latch mode, restart line count, track field parity.
      if (vsync_fall) begin
        vmode    <= (line_cnt > PAL_TH_L);
        line_cnt <= '0;
        field    <= vdata_pre[VW-3];
        tgl_hist <= tgl_next;
        if (tgl_next == 2'b11)
          n64_480i <= 1'b1;
        else if (tgl_next == 2'b00)
          n64_480i <= 1'b0;
      end else if (hsync_rise) begin
        line_cnt <= sat_inc(line_cnt);
      end
    end
  end

endmodule
